// File: rtl/array_pkg.sv
// Shared types and helpers for the array write sequencer (array_loader).
package array_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } loader_state_t;

  // Width of a slot index for an array of n slots (at least one bit).
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_index_counter.sv
// Wrapping slot counter, 0..ELEMENTS-1, with synchronous clear and increment.
// Shared by the frame load and the sweep flush, so the index never leaves range
// even when ELEMENTS is not a power of two.
module array_index_counter
  import array_pkg::*;
#(
  parameter int ELEMENTS    = 4,
  parameter int INDEX_WIDTH = index_width(ELEMENTS)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [INDEX_WIDTH-1:0] count
);

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(ELEMENTS - 1);

  // Count up on inc, wrapping from the last slot back to zero; clr has priority.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + INDEX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/array_loader.sv
// Upstream write sequencer for the Array register bank: accepts elements over
// valid/ready and writes slots 0..ELEMENTS-1 in order, pulses frame_done after
// the last slot, and can flush the bank.
// Build option: define ARRAY_LOADER_SWEEP_EN to flush by writing zero into every
// slot over ELEMENTS cycles; otherwise flush is a single array_clear cycle.
module array_loader
  import array_pkg::*;
#(
  parameter int ELEMENTS = 4,
  parameter int WIDTH    = 8,
  localparam int INDEX_WIDTH = index_width(ELEMENTS)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [WIDTH-1:0]       element,
  output logic                   enable,
  output logic                   array_clear,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(ELEMENTS - 1);

  loader_state_t state;
  loader_state_t next_state;
  logic [INDEX_WIDTH-1:0] count;
  logic cnt_clr;
  logic cnt_inc;
  logic handshake;

  array_index_counter #(
    .ELEMENTS    (ELEMENTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_counter (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (count)
  );

  // Status outputs decode the registered state only, so nothing depends on in_valid.
  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign handshake  = in_valid && in_ready;

`ifdef ARRAY_LOADER_SWEEP_EN
  assign array_clear = 1'b0;
`else
  assign array_clear = (state == FLUSH);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and slot-counter control; flush beats start and aborts a load.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (flush) begin
          next_state = FLUSH;
        end else if (start) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (flush) begin
          next_state = FLUSH;
          cnt_clr    = 1'b1;
        end else if (handshake) begin
          cnt_inc = 1'b1;
          if (count == LAST) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        cnt_clr    = 1'b1;
        next_state = IDLE;
      end
      FLUSH: begin
`ifdef ARRAY_LOADER_SWEEP_EN
        cnt_inc = 1'b1;
        if (count == LAST) begin
          next_state = IDLE;
        end
`else
        next_state = IDLE;
`endif
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered write port towards Array; a dropped handshake never reaches it.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      enable  <= 1'b0;
      index   <= '0;
      element <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (handshake && !flush) begin
            enable  <= 1'b1;
            index   <= count;
            element <= in_data;
          end else begin
            enable <= 1'b0;
          end
        end
        FLUSH: begin
`ifdef ARRAY_LOADER_SWEEP_EN
          enable  <= 1'b1;
          index   <= count;
          element <= '0;
`else
          enable  <= 1'b0;
`endif
        end
        default: begin
          enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_loader.sv
// Directed testbench for array_loader with a behavioural Array + OR-reduction
// stand-in. Honours ARRAY_LOADER_SWEEP_EN for the flush expectations.
module tb_array_loader;

  localparam int ELEMENTS = 4;
  localparam int WIDTH    = 8;
  localparam logic [7:0] FRAME  [4] = '{8'haa, 8'h11, 8'h72, 8'h88};
  localparam logic [7:0] FRAME2 [4] = '{8'hcc, 8'hdd, 8'hee, 8'hff};

  logic       clock = 1'b0;
  logic       clear_n;
  logic       start;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] index;
  logic [7:0] element;
  logic       enable;
  logic       array_clear;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  // Downstream model: Array slots plus activity counters and write log.
  logic [7:0] mem [4];
  int fdCount  = 0;
  int enCount  = 0;
  int clrCount = 0;
  logic [1:0] idxLog [$];
  logic [7:0] datLog [$];

  array_loader #(.ELEMENTS(ELEMENTS), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .index       (index),
    .element     (element),
    .enable      (enable),
    .array_clear (array_clear),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  // Array capture on the rising edge, using the values present before the edge.
  always @(posedge clock) begin
    if (frame_done) fdCount++;
    if (enable) begin
      enCount++;
      idxLog.push_back(index);
      datLog.push_back(element);
    end
    if (array_clear) begin
      clrCount++;
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    end else if (enable) begin
      mem[index] = element;
    end
  end

  function automatic logic [31:0] arrayData();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction

  function automatic logic [7:0] result();
    return mem[0] | mem[1] | mem[2] | mem[3];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step();
    step();
    checks++;
    if ({busy, in_ready, enable, array_clear, frame_done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, in_ready, enable, array_clear, frame_done});
    end
    checks++;
    if ({index, element} !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_port: got index=%h element=%h expected 0/00", index, element);
    end
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    int fd0 = fdCount;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({in_ready, busy, enable} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL load_entry: got ready/busy/enable=%b expected 110", {in_ready, busy, enable});
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = FRAME[i];
      step();
      checks++;
      if ({enable, index, element} !== {1'b1, 2'(i), FRAME[i]}) begin
        errors++;
        $display("[TB] FAIL load_write%0d: got en=%b idx=%0d el=%h expected 1/%0d/%h", i, enable, index, element, i, FRAME[i]);
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({frame_done, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL load_done: got frame_done/busy=%b expected 11", {frame_done, busy});
    end
    step();
    checks++;
    if ({busy, frame_done, enable} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL load_idle: got busy/frame_done/enable=%b expected 000", {busy, frame_done, enable});
    end
    checks++;
    if (arrayData() !== 32'h887211aa || result() !== 8'hfb) begin
      errors++;
      $display("[TB] FAIL load_data: got %h/%h expected 887211aa/fb", arrayData(), result());
    end
    checks++;
    if (fdCount - fd0 !== 1) begin
      errors++;
      $display("[TB] FAIL load_pulses: got %0d expected 1", fdCount - fd0);
    end
  endtask

  task automatic test_bubbles();
    int q0 = idxLog.size();
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = FRAME[0];
    step();
    in_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      step();
      checks++;
      if ({enable, in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL bubble_gap%0d: got enable/ready=%b expected 01", g, {enable, in_ready});
      end
    end
    for (int i = 1; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = FRAME[i];
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (idxLog.size() - q0 !== 4) begin
      errors++;
      $display("[TB] FAIL bubble_writes: got %0d expected 4", idxLog.size() - q0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (idxLog[q0 + k] !== 2'(k)) begin
          errors++;
          $display("[TB] FAIL bubble_index%0d: got %0d expected %0d", k, idxLog[q0 + k], k);
        end
      end
    end
    checks++;
    if (arrayData() !== 32'h887211aa || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bubble_data: got %h busy=%b expected 887211aa busy=0", arrayData(), busy);
    end
  endtask

  task automatic test_flush();
    int en0  = enCount;
    int clr0 = clrCount;
    int n    = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_entry: got busy/ready=%b expected 10", {busy, in_ready});
    end
`ifdef ARRAY_LOADER_SWEEP_EN
    checks++;
    if (array_clear !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clear: got %b expected 0", array_clear);
    end
`else
    checks++;
    if ({array_clear, enable} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_clear: got clear/enable=%b expected 10", {array_clear, enable});
    end
`endif
    while (busy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_timeout: got busy=%b expected 0", busy);
    end
    step();
    checks++;
    if (arrayData() !== 32'h0 || result() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL flush_data: got %h/%h expected 00000000/00", arrayData(), result());
    end
`ifdef ARRAY_LOADER_SWEEP_EN
    checks++;
    if (enCount - en0 !== 4 || clrCount - clr0 !== 0) begin
      errors++;
      $display("[TB] FAIL flush_cycles: got enable=%0d clear=%0d expected 4/0", enCount - en0, clrCount - clr0);
    end
`else
    checks++;
    if (enCount - en0 !== 0 || clrCount - clr0 !== 1) begin
      errors++;
      $display("[TB] FAIL flush_cycles: got enable=%0d clear=%0d expected 0/1", enCount - en0, clrCount - clr0);
    end
`endif
  endtask

  task automatic test_abort();
    int fd0 = fdCount;
    int d0  = datLog.size();
    int n   = 0;
    int saw72 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = FRAME[i];
      step();
    end
    in_data = 8'h72;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({enable, busy, in_ready} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL abort_entry: got enable/busy/ready=%b expected 010", {enable, busy, in_ready});
    end
    while (busy && n < 20) begin
      step();
      n++;
    end
    step();
    for (int k = d0; k < datLog.size(); k++) if (datLog[k] === 8'h72) saw72++;
    checks++;
    if (saw72 !== 0 || fdCount - fd0 !== 0) begin
      errors++;
      $display("[TB] FAIL abort_drop: got writes72=%0d pulses=%0d expected 0/0", saw72, fdCount - fd0);
    end
    checks++;
    if (arrayData() !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_data: got %h busy=%b expected 00000000 busy=0", arrayData(), busy);
    end
  endtask

  task automatic test_reset_mid_load();
    int fd0 = fdCount;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = FRAME[i];
      step();
    end
    in_valid = 1'b0;
    clear_n  = 1'b0;
    step();
    checks++;
    if ({busy, in_ready, enable, array_clear, frame_done, index, element} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got flags=%b idx=%0d el=%h expected all zero",
               {busy, in_ready, enable, array_clear, frame_done}, index, element);
    end
    clear_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = FRAME2[i];
      step();
      checks++;
      if ({enable, index} !== {1'b1, 2'(i)}) begin
        errors++;
        $display("[TB] FAIL midreset_index%0d: got en=%b idx=%0d expected 1/%0d", i, enable, index, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (arrayData() !== 32'hffeeddcc || fdCount - fd0 !== 1) begin
      errors++;
      $display("[TB] FAIL midreset_data: got %h pulses=%0d expected ffeeddcc/1", arrayData(), fdCount - fd0);
    end
  endtask

  task automatic test_simultaneous();
    int fd0 = fdCount;
    int n   = 0;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL simul_state: got busy/ready=%b expected 10", {busy, in_ready});
    end
    while (busy && n < 20) begin
      step();
      n++;
    end
    step();
    checks++;
    if (arrayData() !== 32'h0 || fdCount - fd0 !== 0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_result: got %h pulses=%0d busy=%b ready=%b expected 00000000/0/0/0",
               arrayData(), fdCount - fd0, busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bubbles();
    test_flush();
    test_basic_load();
    test_abort();
    test_reset_mid_load();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
